// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports
// with same-cycle write forwarding, register 0 hardwired to zero, and a
// sequential clear sweep that zeroes registers 1..DEPTH-1 one per cycle.
// The sweep runs on request (clr_req) and after every reset, and while it is
// running the file is "busy": writes are dropped and every read returns zero.

module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                       cpu_clk_50M,
   input  logic                       cpu_rst,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          wa0,
   input  logic [DATA_W-1:0]          wd0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          wa1,
   input  logic [DATA_W-1:0]          wd1,
   input  logic [NUM_RD-1:0]          re,
   input  logic [NUM_RD*ADDR_W-1:0]   ra,
   output logic [NUM_RD*DATA_W-1:0]   rd,
   input  logic                       clr_req,
   output logic                       busy
);

   localparam int DEPTH = 1 << ADDR_W;

   // The sweep starts at 1 because register 0 never holds anything but zero,
   // and stops at the last address so the counter can never wrap.
   localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q,   cnt_d;
   logic                busy_q,  busy_d;

   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   regs_d [DEPTH];

   logic [ADDR_W-1:0]   ra_k;
   logic [DATA_W-1:0]   rd_k;

   assign busy = busy_q;

   // Controller next state: IDLE waits for a clear request, CLEAR walks the
   // counter up to the last address and then falls back to IDLE. Requests
   // arriving during CLEAR are simply not looked at.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = CNT_FIRST;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_FIRST;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   // Controller registers; reset restarts the sweep from address 1 so the
   // whole file is guaranteed zero once busy drops after a reset.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= CNT_FIRST;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // Storage next value: user writes when idle (port 1 applied last so it wins
   // a same-address collision), one register zeroed per cycle while sweeping,
   // nothing at all during reset. Register 0 is forced back to zero every cycle.
   always_comb begin
      regs_d = regs_q;
      if (!cpu_rst) begin
         if (!busy_q) begin
            if (we0 && (wa0 != '0)) begin
               regs_d[wa0] = wd0;
            end
            if (we1 && (wa1 != '0)) begin
               regs_d[wa1] = wd1;
            end
         end
         if (state_q == ST_CLEAR) begin
            regs_d[cnt_q] = '0;
         end
      end
      regs_d[0] = '0;
   end

   // Storage array; it carries no reset of its own because the sweep that
   // follows every reset is what zeroes it.
   always_ff @(posedge cpu_clk_50M) begin
      regs_q <= regs_d;
   end

   // Read ports: independent combinational lookups. Disabled ports, address 0,
   // reset and an active sweep all read zero; otherwise an in-flight write to
   // the same address is forwarded (port 1 ahead of port 0) before the array.
   always_comb begin
      rd   = '0;
      ra_k = '0;
      rd_k = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra_k = ra[k*ADDR_W +: ADDR_W];
         if (cpu_rst || !re[k] || (ra_k == '0) || busy_q) begin
            rd_k = '0;
         end else if (we1 && (wa1 == ra_k)) begin
            rd_k = wd1;
         end else if (we0 && (wa0 == ra_k)) begin
            rd_k = wd0;
         end else begin
            rd_k = regs_q[ra_k];
         end
         rd[k*DATA_W +: DATA_W] = rd_k;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters. Expected read data and
// busy values are queued as stimulus is applied and compared against the DUT
// half a cycle after the driving edge.

module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int SWEEP_LEN = (1 << ADDR_W) - 1;
   localparam int WAIT_LIMIT = 100;

   logic                      cpu_clk_50M = 1'b0;
   logic                      cpu_rst;
   logic                      we0, we1;
   logic [ADDR_W-1:0]         wa0, wa1;
   logic [DATA_W-1:0]         wd0, wd1;
   logic [NUM_RD-1:0]         re;
   logic [NUM_RD*ADDR_W-1:0]  ra;
   logic [NUM_RD*DATA_W-1:0]  rd;
   logic                      clr_req;
   logic                      busy;

   int checks = 0;
   int errors = 0;
   int n;

   typedef struct {
      bit          is_busy;
      int          port;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];

   regfile_mp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst     (cpu_rst),
      .we0         (we0),
      .wa0         (wa0),
      .wd0         (wd0),
      .we1         (we1),
      .wa1         (wa1),
      .wd1         (wd1),
      .re          (re),
      .ra          (ra),
      .rd          (rd),
      .clr_req     (clr_req),
      .busy        (busy)
   );

   // 50 MHz clock
   always #10 cpu_clk_50M = ~cpu_clk_50M;

   // Hard stop in case something never returns
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic apply_stimulus(input logic w0, input logic [ADDR_W-1:0] a0,
                                 input logic [DATA_W-1:0] d0,
                                 input logic w1, input logic [ADDR_W-1:0] a1,
                                 input logic [DATA_W-1:0] d1,
                                 input logic [NUM_RD-1:0] r,
                                 input logic [NUM_RD*ADDR_W-1:0] ras,
                                 input logic clr, input logic rst);
      we0     = w0;
      wa0     = a0;
      wd0     = d0;
      we1     = w1;
      wa1     = a1;
      wd1     = d1;
      re      = r;
      ra      = ras;
      clr_req = clr;
      cpu_rst = rst;
   endtask

   task automatic expect_rd(input int port, input logic [31:0] val, input string tag);
      exp_t e;
      e.is_busy = 1'b0;
      e.port    = port;
      e.val     = val;
      e.tag     = tag;
      sb.push_back(e);
   endtask

   task automatic expect_busy(input logic val, input string tag);
      exp_t e;
      e.is_busy = 1'b1;
      e.port    = 0;
      e.val     = {31'b0, val};
      e.tag     = tag;
      sb.push_back(e);
   endtask

   task automatic check_output();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_busy) obs = {31'b0, busy};
         else           obs = rd[e.port*DATA_W +: DATA_W];
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic check_value(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   initial begin
      // Scenario 1: one-cycle reset with a write attempt, then a full sweep
      apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd3, 5'd5}, 1'b0, 1'b1);
      @(negedge cpu_clk_50M);
      expect_busy(1'b1, "rst_busy");
      expect_rd(0, 32'h0, "rst_rd0");
      expect_rd(1, 32'h0, "rst_rd1");
      check_output();
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd3, 5'd5}, 1'b0, 1'b0);
      n = 0;
      while (busy === 1'b1 && n < WAIT_LIMIT) begin
         n++;
         @(negedge cpu_clk_50M);
      end
      check_value("s1_busy_len", n, SWEEP_LEN);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd31, 5'd5}, 1'b0, 1'b0);
      expect_busy(1'b0, "s1_idle");
      expect_rd(0, 32'h0, "s1_rd_a5");
      expect_rd(1, 32'h0, "s1_rd_a31");
      check_output();

      // Scenario 2: forwarding then stored value, disabled port reads zero
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0,
                     2'b01, {5'd5, 5'd5}, 1'b0, 1'b0);
      expect_rd(0, 32'h1234_5678, "s2_fwd");
      expect_rd(1, 32'h0, "s2_re_off");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd5, 5'd5}, 1'b0, 1'b0);
      expect_rd(0, 32'h1234_5678, "s2_stored0");
      expect_rd(1, 32'h1234_5678, "s2_stored1");
      check_output();

      // Scenario 3: same-address collision, port 1 wins
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'h5555_FFFF,
                     2'b01, {5'd0, 5'd7}, 1'b0, 1'b0);
      expect_rd(0, 32'h5555_FFFF, "s3_fwd");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd7, 5'd7}, 1'b0, 1'b0);
      expect_rd(0, 32'h5555_FFFF, "s3_stored0");
      expect_rd(1, 32'h5555_FFFF, "s3_stored1");
      check_output();
      @(negedge cpu_clk_50M);
      expect_rd(0, 32'h5555_FFFF, "s3_later");
      check_output();

      // Both write ports to different addresses, then forwarding over stored
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd12, 32'h0C0C_0C0C, 1'b1, 5'd9, 32'hCAFE_F00D,
                     2'b11, {5'd9, 5'd12}, 1'b0, 1'b0);
      expect_rd(0, 32'h0C0C_0C0C, "dual_fwd0");
      expect_rd(1, 32'hCAFE_F00D, "dual_fwd1");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd12, 5'd9}, 1'b0, 1'b0);
      expect_rd(0, 32'hCAFE_F00D, "dual_st9");
      expect_rd(1, 32'h0C0C_0C0C, "dual_st12");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd9, 32'h9999_9999, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd12, 5'd9}, 1'b0, 1'b0);
      expect_rd(0, 32'h9999_9999, "fwd_over_st");
      expect_rd(1, 32'h0C0C_0C0C, "other_port");
      check_output();

      // Scenario 4: writes to register 0 are dropped, address 0 reads zero
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF,
                     2'b11, {5'd0, 5'd0}, 1'b0, 1'b0);
      expect_rd(0, 32'h0, "s4_same0");
      expect_rd(1, 32'h0, "s4_same1");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd0, 5'd0}, 1'b0, 1'b0);
      expect_rd(0, 32'h0, "s4_next0");
      expect_rd(1, 32'h0, "s4_next1");
      check_output();

      // Scenario 5: clear sweep ignores writes and reads zero while busy
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,
                     2'b01, {5'd0, 5'd3}, 1'b0, 1'b0);
      expect_rd(0, 32'h11, "s5_fwd");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b01, {5'd0, 5'd3}, 1'b1, 1'b0);
      expect_busy(1'b0, "s5_req_busy");
      expect_rd(0, 32'h11, "s5_pre");
      check_output();
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'h0,
                     2'b01, {5'd0, 5'd3}, 1'b0, 1'b0);
      expect_busy(1'b1, "s5_busy");
      expect_rd(0, 32'h0, "s5_busy_rd");
      check_output();
      n = 0;
      while (busy === 1'b1 && n < WAIT_LIMIT) begin
         n++;
         @(negedge cpu_clk_50M);
      end
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b01, {5'd0, 5'd3}, 1'b0, 1'b0);
      check_value("s5_busy_len", n, SWEEP_LEN);
      expect_busy(1'b0, "s5_done");
      expect_rd(0, 32'h0, "s5_after");
      check_output();

      // Scenario 6: reset at the 10th busy cycle restarts the sweep;
      // clr_req inside the restarted window (including its last cycle) is ignored
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 32'h0,
                     2'b00, {5'd0, 5'd0}, 1'b0, 1'b0);
      @(negedge cpu_clk_50M);
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     2'b11, {5'd12, 5'd12}, 1'b0, 1'b0);
      expect_rd(0, 32'h77, "s6_pre0");
      expect_rd(1, 32'h77, "s6_pre1");
      check_output();
      @(negedge cpu_clk_50M);
      clr_req = 1'b1;
      @(negedge cpu_clk_50M);
      clr_req = 1'b0;
      expect_busy(1'b1, "s6_busy1");
      check_output();
      repeat (9) @(negedge cpu_clk_50M);
      cpu_rst = 1'b1;
      expect_busy(1'b1, "s6_busy10");
      expect_rd(0, 32'h0, "s6_rst_rd0");
      expect_rd(1, 32'h0, "s6_rst_rd1");
      check_output();
      @(negedge cpu_clk_50M);
      cpu_rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < WAIT_LIMIT) begin
         n++;
         clr_req = (n == 5 || n == SWEEP_LEN);
         @(negedge cpu_clk_50M);
      end
      clr_req = 1'b0;
      check_value("s6_busy_len", n, SWEEP_LEN);
      expect_busy(1'b0, "s6_done");
      expect_rd(0, 32'h0, "s6_swept0");
      expect_rd(1, 32'h0, "s6_swept1");
      check_output();
      @(negedge cpu_clk_50M);
      expect_busy(1'b0, "s6_no_queue");
      check_output();
      @(negedge cpu_clk_50M);
      expect_busy(1'b0, "s6_still_idle");
      check_output();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the register width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, giving the address width; DEPTH = 2^ADDR_W registers.
REQ-003 The module SHALL have parameter NUM_RD, default 2, giving the number of read ports (NUM_RD >= 1).
REQ-004 The module SHALL have cpu_clk_50M  in  1  as its single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have cpu_rst  in  1  as its reset, which is synchronous and active-high.
REQ-006 The module SHALL have write port 0: we0 in 1 (enable), wa0 in ADDR_W (address), wd0 in DATA_W (data).
REQ-007 The module SHALL have write port 1: we1 in 1 (enable), wa1 in ADDR_W (address), wd1 in DATA_W (data).
REQ-008 The module SHALL have re  in  NUM_RD, with bit k as the read enable of read port k.
REQ-009 The module SHALL have ra  in  NUM_RD*ADDR_W, with slice [k*ADDR_W +: ADDR_W] as the address of port k.
REQ-010 The module SHALL have rd  out  NUM_RD*DATA_W, with slice [k*DATA_W +: DATA_W] as the combinational data of port k.
REQ-011 The module SHALL have clr_req  in  1, a single-cycle request to zero the whole file.
REQ-012 The module SHALL have busy  out  1, which is high while a clear sweep is in progress.

Function
REQ-013 Register 0 SHALL read as zero at all times, and any write addressed to 0 SHALL be discarded.
REQ-014 An enabled write SHALL update the stored register on the rising edge that samples it.
REQ-015 When both write ports are enabled to the same nonzero address, write port 1 SHALL win.
REQ-016 Each read port k SHALL drive rd_k using the first matching rule, in this priority order:
- re[k]=0: zero.
- ra_k=0: zero.
- busy=1: zero.
- we1 && wa1==ra_k: wd1.
- we0 && wa0==ra_k: wd0.
- Otherwise: the stored value.
REQ-017 The read paths SHALL be purely combinational, with zero-cycle latency, including same-cycle write forwarding.
REQ-018 The controller SHALL be a two-state FSM, IDLE and CLEAR, and busy SHALL be a registered decode of (state==CLEAR).
REQ-019 In IDLE, clr_req=1 SHALL move the FSM to CLEAR on the next edge and load the sweep counter with 1.
REQ-020 Writes presented in the same cycle as clr_req SHALL commit normally.
REQ-021 In CLEAR, each cycle SHALL zero regs[cnt] and increment cnt.
REQ-022 When cnt==DEPTH-1 in CLEAR, that register SHALL be zeroed and the FSM SHALL return to IDLE, so busy is high for exactly DEPTH-1 cycles (31 at default).
REQ-023 clr_req SHALL be ignored while in CLEAR, with no restart and no queuing.
REQ-024 we0 and we1 SHALL be ignored while busy=1.
REQ-025 The sweep counter SHALL be ADDR_W bits wide and SHALL never wrap past DEPTH-1.
REQ-026 All reads on all NUM_RD ports SHALL be independent, with no read-port arbitration or stalls.

Reset
REQ-027 While cpu_rst is sampled high, the FSM SHALL load CLEAR with cnt=1, so busy=1 from the first edge after assertion.
REQ-028 While cpu_rst=1, all rd slices SHALL read zero and writes SHALL be ignored.
REQ-029 After cpu_rst deasserts, the sweep SHALL run to completion, so busy stays high for DEPTH-1 cycles after release and all registers read zero afterwards.
REQ-030 Reset asserted mid-sweep SHALL restart the sweep at cnt=1.
REQ-031 No storage element SHALL depend on an asynchronous reset.

Verification
REQ-032 Scenario 1: 1-cycle cpu_rst, then release -> busy=1 for exactly 31 cycles, then 0; reading any address returns 0x00000000.
REQ-033 Scenario 2: we0=1, wa0=5, wd0=0x12345678 with re[0]=1, ra_0=5 in the same cycle -> rd_0=0x12345678 that cycle (forwarded); with we0=0 next cycle -> rd_0 still 0x12345678 (stored).
REQ-034 Scenario 3: we0=1, wa0=7, wd0=0xAAAA0000 and we1=1, wa1=7, wd1=0x5555FFFF -> rd on ra=7 is 0x5555FFFF that cycle and all following cycles.
REQ-035 Scenario 4: we0=1, wa0=0, wd0=0xFFFFFFFF; re=all 1s, ra=all 0s -> every rd slice is 0x00000000, both that cycle and the next.
REQ-036 Scenario 5: reg3=0x11, pulse clr_req; during busy, we0=1, wa0=3, wd0=0x22 -> the write is ignored, rd on ra=3 reads 0 while busy, and reads 0x00000000 after busy falls.
REQ-037 Scenario 6: assert cpu_rst for one cycle at the 10th busy cycle of a sweep -> busy stays high for 31 cycles after release, and a clr_req pulsed during that window has no effect.
